four_in_16_out_shift_reg: RTL and testbench

FOUR_IN_16_OUT_SHIFT_REG -- requirements
Module: four_in_16_out_shift_reg

---
 rtl/four_in_16_out_shift_reg.sv | 56 +++++
 tb/tb_four_in_16_out_shift_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/four_in_16_out_shift_reg.sv
// Four-digit hex entry shift register. An asynchronous trig strobe is synchronized and
// edge-detected; each press shifts the in digit into out[3:0] and bumps a saturating count.
module four_in_16_out_shift_reg #(
  parameter int unsigned SYNC_STAGES = 2  // 2..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in,
  input  logic        trig,
  output logic [15:0] out,
  output logic [2:0]  count,
  output logic        full
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [15:0]            out_q, out_d;
  logic [2:0]             count_q, count_d;
  logic                   trig_pulse;

  // Rising edge of the synchronized strobe; clearing the flops on reset makes a held trig
  // look like a fresh press once reset drops.
  assign trig_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], trig};
    hist_d  = sync_q[SYNC_STAGES-1];
    out_d   = out_q;
    count_d = count_q;
    if (trig_pulse) begin
      out_d = {out_q[11:0], in};
      if (count_q < 3'd4) begin
        count_d = count_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      out_q   <= 16'h0000;
      count_q <= 3'd0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      out_q   <= out_d;
      count_q <= count_d;
    end
  end

  assign out   = out_q;
  assign count = count_q;
  assign full  = (count_q == 3'd4);

endmodule

// File: tb/tb_four_in_16_out_shift_reg.sv
// Directed bench for four_in_16_out_shift_reg: table of presses plus hand-written
// sequences for long trig, latency, reset collision and trig held across reset.
module tb_four_in_16_out_shift_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in = 4'h0;
  logic        trig = 1'b0;
  logic [15:0] out;
  logic [2:0]  count;
  logic        full;

  int n_pass = 0;
  int n_total = 0;

  four_in_16_out_shift_reg #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .trig  (trig),
    .out   (out),
    .count (count),
    .full  (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  din;
    int          hold;
    logic [15:0] exp_out;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[11];

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  task automatic check_state(input string name, input logic [15:0] eo, input logic [2:0] ec);
    check({name, ".out"}, out, eo);
    check({name, ".count"}, {13'd0, count}, {13'd0, ec});
    check({name, ".full"}, {15'd0, full}, {15'd0, (ec == 3'd4)});
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    in   = d;
    trig = 1'b1;
    tick(hold);
    trig = 1'b0;
    tick(5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{din: 4'h0, hold: 2,  exp_out: 16'h0000, exp_count: 3'd1};
    vecs[1]  = '{din: 4'h4, hold: 2,  exp_out: 16'h0004, exp_count: 3'd2};
    vecs[2]  = '{din: 4'h3, hold: 2,  exp_out: 16'h0043, exp_count: 3'd3};
    vecs[3]  = '{din: 4'h2, hold: 2,  exp_out: 16'h0432, exp_count: 3'd4};
    vecs[4]  = '{din: 4'h1, hold: 2,  exp_out: 16'h4321, exp_count: 3'd4};
    vecs[5]  = '{din: 4'hF, hold: 2,  exp_out: 16'h321F, exp_count: 3'd4};
    vecs[6]  = '{din: 4'hF, hold: 2,  exp_out: 16'h21FF, exp_count: 3'd4};
    vecs[7]  = '{din: 4'hF, hold: 2,  exp_out: 16'h1FFF, exp_count: 3'd4};
    vecs[8]  = '{din: 4'hF, hold: 2,  exp_out: 16'hFFFF, exp_count: 3'd4};
    vecs[9]  = '{din: 4'hA, hold: 1,  exp_out: 16'hFFFA, exp_count: 3'd4};
    vecs[10] = '{din: 4'h5, hold: 20, exp_out: 16'hFFA5, exp_count: 3'd4};

    // Reset
    tick(1);
    do_reset();
    check_state("reset", 16'h0000, 3'd0);

    // Entry and overflow table
    for (int i = 0; i < 11; i++) begin
      press(vecs[i].din, vecs[i].hold);
      check_state($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_count);
    end

    // Long trig: one shift only, later in changes ignored
    do_reset();
    in   = 4'h5;
    trig = 1'b1;
    tick(3);
    check_state("long.first", 16'h0005, 3'd1);
    in = 4'h9;
    tick(17);
    check_state("long.held", 16'h0005, 3'd1);
    trig = 1'b0;
    tick(5);
    check_state("long.release", 16'h0005, 3'd1);

    // Latency: trig rises before edge N, shift lands on edge N+2
    in   = 4'hC;
    trig = 1'b1;
    tick(1);
    check_state("lat.edgeN", 16'h0005, 3'd1);
    tick(1);
    check_state("lat.edgeN1", 16'h0005, 3'd1);
    tick(1);
    check_state("lat.edgeN2", 16'h005C, 3'd2);
    in = 4'h3;
    tick(3);
    check_state("lat.after", 16'h005C, 3'd2);
    trig = 1'b0;
    tick(5);
    check_state("lat.release", 16'h005C, 3'd2);

    // Reset colliding with trig_pulse: pulse dropped, not deferred
    do_reset();
    press(4'h7, 2);
    press(4'h7, 2);
    check_state("coll.pre", 16'h0077, 3'd2);
    in   = 4'h8;
    trig = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst  = 1'b0;
    trig = 1'b0;
    check_state("coll.reset", 16'h0000, 3'd0);
    tick(6);
    check_state("coll.nodefer", 16'h0000, 3'd0);
    press(4'h6, 2);
    check_state("coll.next", 16'h0006, 3'd1);

    // trig held across reset deassertion counts as one new press
    in   = 4'h1;
    trig = 1'b1;
    rst  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check_state("hold_rst.shift", 16'h0001, 3'd1);
    tick(6);
    check_state("hold_rst.once", 16'h0001, 3'd1);
    trig = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
